// File: rtl/func_ctrl_pkg.sv
// Shared types and helpers for the function-unit controller.
// Holds the FSM state enum and a ceiling-divide helper for buffer sizing.
package func_ctrl_pkg;

    typedef enum logic [1:0] {
        s_func_idle    = 2'd0,
        s_func_read    = 2'd1,
        s_func_drain   = 2'd2,
        s_func_handoff = 2'd3
    } t_func_ctrl_state;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/func_ctrl_act.sv
// Single-lane activation: ReLU, arithmetic right shift, unsigned saturation.
// Ports: x (signed ACC_WIDTH partial sum) -> y (DATA_SIZE activation).
// Requires ACC_WIDTH > DATA_SIZE and DATA_SIZE < 31.
module func_act #(
    parameter int DATA_SIZE = 8,
    parameter int ACC_WIDTH = 16,
    parameter int SHIFT     = 4
) (
    input  logic [ACC_WIDTH-1:0] x,
    output logic [DATA_SIZE-1:0] y
);

    localparam logic [ACC_WIDTH-1:0] MAX_VAL =
        ACC_WIDTH'((1 << DATA_SIZE) - 1);

    logic [ACC_WIDTH-1:0] shifted;

    // Negative inputs are zeroed first, so a logical shift is
    // equivalent to the arithmetic one on what remains.
    assign shifted = x >> SHIFT;

    always_comb begin
        y = '0;
        if (x[ACC_WIDTH-1]) begin
            y = '0;
        end else if (shifted > MAX_VAL) begin
            y = MAX_VAL[DATA_SIZE-1:0];
        end else begin
            y = shifted[DATA_SIZE-1:0];
        end
    end

endmodule

// File: rtl/func_ctrl.sv
// Function-unit controller: reads CIM partial sums, applies activation,
// writes the output buffer, then hands off to the next layer.
// Ports: clk/rst; i_start/o_ready (upstream handshake);
//        o_rd_en/o_rd_addr/i_rd_data (read buffer);
//        o_obuf_we/o_obuf_addr/o_obuf_data (output buffer);
//        o_next_start/i_next_ready (downstream handshake).
module func_ctrl
    import func_ctrl_pkg::*;
#(
    parameter int DATA_SIZE       = 8,
    parameter int ACC_WIDTH       = 16,
    parameter int OUTPUT_CHANNELS = 16,
    parameter int BUS_WIDTH       = 4,
    parameter int SHIFT           = 4,
    localparam int NUM_ADDR   = ceil_div(OUTPUT_CHANNELS, BUS_WIDTH),
    localparam int ADDR_WIDTH = (NUM_ADDR <= 1) ? 1 : $clog2(NUM_ADDR)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_start,
    output logic                           o_ready,
    output logic                           o_rd_en,
    output logic [ADDR_WIDTH-1:0]          o_rd_addr,
    input  logic [BUS_WIDTH*ACC_WIDTH-1:0] i_rd_data,
    output logic                           o_obuf_we,
    output logic [ADDR_WIDTH-1:0]          o_obuf_addr,
    output logic [BUS_WIDTH*DATA_SIZE-1:0] o_obuf_data,
    output logic                           o_next_start,
    input  logic                           i_next_ready
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ADDR - 1);

    t_func_ctrl_state state, state_n;
    logic [ADDR_WIDTH-1:0] cnt, cnt_n;
    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;

    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  ready;
    logic                  next_start;

    logic [BUS_WIDTH*DATA_SIZE-1:0] act_bus;

    for (genvar j = 0; j < BUS_WIDTH; j++) begin : g_lane
        func_act #(
            .DATA_SIZE (DATA_SIZE),
            .ACC_WIDTH (ACC_WIDTH),
            .SHIFT     (SHIFT)
        ) u_act (
            .x (i_rd_data[j*ACC_WIDTH +: ACC_WIDTH]),
            .y (act_bus[j*DATA_SIZE +: DATA_SIZE])
        );
    end

    // The write pipeline trails the read by one cycle to match the
    // read-buffer latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= s_func_idle;
            cnt      <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            wr_valid <= rd_en;
            wr_addr  <= rd_addr;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        rd_en      = 1'b0;
        rd_addr    = '0;
        ready      = 1'b0;
        next_start = 1'b0;
        case (state)
            s_func_idle: begin
                // Holding off until the next layer is ready keeps the
                // output buffer from being overwritten mid-consumption.
                ready = i_next_ready;
                cnt_n = '0;
                if (i_start && i_next_ready) begin
                    state_n = s_func_read;
                end
            end
            s_func_read: begin
                rd_en   = 1'b1;
                rd_addr = cnt;
                if (cnt == LAST_ADDR) begin
                    cnt_n   = '0;
                    state_n = s_func_drain;
                end else begin
                    cnt_n = cnt + ADDR_WIDTH'(1);
                end
            end
            s_func_drain: begin
                state_n = s_func_handoff;
            end
            s_func_handoff: begin
                next_start = 1'b1;
                if (i_next_ready) begin
                    state_n = s_func_idle;
                end
            end
            default: begin
                state_n = s_func_idle;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are forced quiet while rst is held; o_ready behaves as
    // in idle since that is where reset lands.
    assign o_ready      = rst ? i_next_ready : ready;
    assign o_rd_en      = rd_en & ~rst;
    assign o_rd_addr    = rst ? '0 : rd_addr;
    assign o_obuf_we    = wr_valid & ~rst;
    assign o_obuf_addr  = o_obuf_we ? wr_addr : '0;
    assign o_obuf_data  = o_obuf_we ? act_bus : '0;
    assign o_next_start = next_start & ~rst;

endmodule
